// File: rtl/tx_pkg.sv
// tx_pkg: shared state encoding, flag indices and default watermarks for the TX flow controller
package tx_pkg;
  localparam int TX_CNT_W = 5;
  localparam int TX_DEPTH = 16;
  localparam int TX_VC_BIT = 5;
  localparam int TX_DEST_BIT = 4;
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
  localparam int F_MAIN = 0;
  localparam int F_VC0 = 1;
  localparam int F_VC1 = 2;
  localparam int F_D0 = 3;
  localparam int F_D1 = 4;
  localparam int DEF_LOW = 1;
  localparam int DEF_HIGH = TX_DEPTH - 1;
endpackage

// File: rtl/tx_wm_cmp.sv
// tx_wm_cmp: latched low/high watermarks of one FIFO with registered almost_full/almost_empty
module tx_wm_cmp
  import tx_pkg::*;
#(
  parameter int CNT_W = TX_CNT_W,
  parameter int DEPTH = TX_DEPTH,
  parameter int HIGH_RST = DEF_HIGH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [CNT_W-1:0] low_in,
  input  logic [CNT_W-1:0] high_in,
  input  logic [CNT_W:0]   cnt,
  output logic [CNT_W:0]   high,
  output logic             af,
  output logic             ae,
  output logic             valid
);
  logic [CNT_W-1:0] low_q, high_q;
  assign high = {1'b0, high_q};
  assign valid = (low_q < high_q) && (int'(high_q) <= DEPTH);
  // capture thresholds on request and register the watermark flags every cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      low_q  <= CNT_W'(DEF_LOW);
      high_q <= CNT_W'(HIGH_RST);
      af     <= 1'b0;
      ae     <= 1'b0;
    end else begin
      if (cap) begin
        low_q  <= low_in;
        high_q <= high_in;
      end
      af <= cnt >= {1'b0, high_q};
      ae <= cnt <= {1'b0, low_q};
    end
endmodule

// File: rtl/tx_flow_ctrl.sv
// tx_flow_ctrl: TX sequencing FSM, MAIN_PAUSE back-pressure and main/VC pop arbitration; TX_RR_ARB_EN selects round-robin VC arbitration
module tx_flow_ctrl
  import tx_pkg::*;
#(
  parameter int CNT_W = TX_CNT_W,
  parameter int DEPTH = TX_DEPTH
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             init,
  input  logic [CNT_W-1:0] main_fifo_low,
  input  logic [CNT_W-1:0] main_fifo_high,
  input  logic [CNT_W-1:0] Vco_low,
  input  logic [CNT_W-1:0] Vco_high,
  input  logic [CNT_W-1:0] Vc1_low,
  input  logic [CNT_W-1:0] Vc1_high,
  input  logic [CNT_W-1:0] Do_low,
  input  logic [CNT_W-1:0] Do_high,
  input  logic [CNT_W-1:0] D1_low,
  input  logic [CNT_W-1:0] D1_high,
  input  logic [CNT_W:0]   main_cnt,
  input  logic [CNT_W:0]   vc0_cnt,
  input  logic [CNT_W:0]   vc1_cnt,
  input  logic [CNT_W:0]   d0_cnt,
  input  logic [CNT_W:0]   d1_cnt,
  input  logic             main_head_vc,
  input  logic             vc0_head_dest,
  input  logic             vc1_head_dest,
  output logic             MAIN_PAUSE,
  output logic             pop_main,
  output logic             pop_vc0,
  output logic             pop_vc1,
  output logic [4:0]       almost_full,
  output logic [4:0]       almost_empty,
  output logic [2:0]       state,
  output logic             idle,
  output logic             error
);
  localparam logic [CNT_W:0] DEP = (CNT_W + 1)'(DEPTH);
  state_t st, nxt;
  logic [CNT_W:0] cnt [5];
  logic [CNT_W:0] high [5];
  logic [CNT_W-1:0] lo_in [5];
  logic [CNT_W-1:0] hi_in [5];
  logic [4:0] valid;
  logic cap, ovf, any_nz, act, el0, el1, pick0;
  assign cnt = '{main_cnt, vc0_cnt, vc1_cnt, d0_cnt, d1_cnt};
  assign lo_in = '{main_fifo_low, Vco_low, Vc1_low, Do_low, D1_low};
  assign hi_in = '{main_fifo_high, Vco_high, Vc1_high, Do_high, D1_high};
  assign cap = (st == S_INIT) && init;
  assign ovf = (main_cnt > DEP) || (vc0_cnt > DEP) || (vc1_cnt > DEP) || (d0_cnt > DEP) || (d1_cnt > DEP);
  assign any_nz = |{main_cnt, vc0_cnt, vc1_cnt, d0_cnt, d1_cnt};
  assign state = st;
  for (genvar i = 0; i < 5; i++) begin : g_wm
    tx_wm_cmp #(.CNT_W(CNT_W), .DEPTH(DEPTH), .HIGH_RST(DEPTH - 1)) u_wm (
      .clk(clk),
      .rst(RESET),
      .cap(cap),
      .low_in(lo_in[i]),
      .high_in(hi_in[i]),
      .cnt(cnt[i]),
      .high(high[i]),
      .af(almost_full[i]),
      .ae(almost_empty[i]),
      .valid(valid[i])
    );
  end
  // next state: overflow beats everything, including a pending init request
  always_comb
    nxt = ovf ? S_ERROR :
          st == S_RESET  ? S_INIT :
          st == S_INIT   ? (init ? S_INIT : (&valid ? S_IDLE : S_ERROR)) :
          st == S_IDLE   ? (init ? S_INIT : (any_nz ? S_ACTIVE : S_IDLE)) :
          st == S_ACTIVE ? (init ? S_INIT : (any_nz ? S_ACTIVE : S_IDLE)) :
          S_ERROR;
  // state register with outputs registered from the next state so they align with it
  always_ff @(posedge clk or posedge RESET)
    if (RESET) begin
      st         <= S_RESET;
      idle       <= 1'b0;
      error      <= 1'b0;
      MAIN_PAUSE <= 1'b0;
    end else begin
      st         <= nxt;
      idle       <= nxt == S_IDLE;
      error      <= nxt == S_ERROR;
      MAIN_PAUSE <= (main_cnt >= high[F_MAIN]) || (nxt == S_INIT) || (nxt == S_ERROR);
    end
  assign act = (st == S_ACTIVE) && !init && !ovf;
  assign pop_main = act && (main_cnt != '0) &&
                    (main_head_vc ? (vc1_cnt < high[F_VC1]) : (vc0_cnt < high[F_VC0]));
  assign el0 = (vc0_cnt != '0) && (vc0_head_dest ? (d1_cnt < high[F_D1]) : (d0_cnt < high[F_D0]));
  assign el1 = (vc1_cnt != '0) && (vc1_head_dest ? (d1_cnt < high[F_D1]) : (d0_cnt < high[F_D0]));
`ifdef TX_RR_ARB_EN
  logic last_grant;
  assign pick0 = el0 && (!el1 || last_grant);
  // remember which VC was served last; only real pops move the pointer
  always_ff @(posedge clk or posedge RESET)
    if (RESET) last_grant <= 1'b1;
    else if (pop_vc0 || pop_vc1) last_grant <= pop_vc1;
`else
  assign pick0 = el0;
`endif
  assign pop_vc0 = act && pick0;
  assign pop_vc1 = act && el1 && !pick0;
endmodule

// File: tb/tb_tx_flow_ctrl.sv
// tb_tx_flow_ctrl: directed scoreboard bench for tx_flow_ctrl
module tb_tx_flow_ctrl;
  logic clk = 0, RESET, init;
  logic [4:0] main_fifo_low, main_fifo_high, Vco_low, Vco_high, Vc1_low, Vc1_high, Do_low, Do_high, D1_low, D1_high;
  logic [5:0] main_cnt, vc0_cnt, vc1_cnt, d0_cnt, d1_cnt;
  logic main_head_vc, vc0_head_dest, vc1_head_dest;
  logic MAIN_PAUSE, pop_main, pop_vc0, pop_vc1, idle, error;
  logic [4:0] almost_full, almost_empty;
  logic [2:0] state;
  int total = 0, bad = 0;
  localparam int ALL = 31, SP = 7;
`ifdef TX_RR_ARB_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif
  typedef struct {
    string nm;
    int m, st, pm, p0, p1, ps, af, ae;
  } exp_t;
  exp_t q[$];

  tx_flow_ctrl dut (
    .clk(clk), .RESET(RESET), .init(init),
    .main_fifo_low(main_fifo_low), .main_fifo_high(main_fifo_high),
    .Vco_low(Vco_low), .Vco_high(Vco_high), .Vc1_low(Vc1_low), .Vc1_high(Vc1_high),
    .Do_low(Do_low), .Do_high(Do_high), .D1_low(D1_low), .D1_high(D1_high),
    .main_cnt(main_cnt), .vc0_cnt(vc0_cnt), .vc1_cnt(vc1_cnt), .d0_cnt(d0_cnt), .d1_cnt(d1_cnt),
    .main_head_vc(main_head_vc), .vc0_head_dest(vc0_head_dest), .vc1_head_dest(vc1_head_dest),
    .MAIN_PAUSE(MAIN_PAUSE), .pop_main(pop_main), .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .almost_full(almost_full), .almost_empty(almost_empty), .state(state), .idle(idle), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int ex);
    total++;
    if (act != ex) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, ex);
    end
  endtask

  task automatic rchk(input string nm);
    #1;
    chk({nm, ".state"}, int'(state), 0);
    chk({nm, ".pause"}, int'(MAIN_PAUSE), 0);
    chk({nm, ".pops"}, int'({pop_main, pop_vc0, pop_vc1}), 0);
    chk({nm, ".af"}, int'(almost_full), 0);
    chk({nm, ".ae"}, int'(almost_empty), 0);
    chk({nm, ".idle_err"}, int'({idle, error}), 0);
  endtask

  task automatic ex(input string nm, input int m, st, pm, p0, p1, ps, input int af = 0, input int ae = 0);
    exp_t e;
    e = '{nm, m, st, pm, p0, p1, ps, af, ae};
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic setc(input int m, v0, v1, d0, d1);
    main_cnt = 6'(m); vc0_cnt = 6'(v0); vc1_cnt = 6'(v1); d0_cnt = 6'(d0); d1_cnt = 6'(d1);
  endtask

  // monitor: after every active edge compare the DUT against the oldest pending expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.m & 1) begin
        chk({e.nm, ".state"}, int'(state), e.st);
        chk({e.nm, ".idle"}, int'(idle), int'(e.st == 2));
        chk({e.nm, ".error"}, int'(error), int'(e.st == 4));
      end
      if (e.m & 2) chk({e.nm, ".pops"}, int'({pop_main, pop_vc0, pop_vc1}), e.pm * 4 + e.p0 * 2 + e.p1);
      if (e.m & 4) chk({e.nm, ".pause"}, int'(MAIN_PAUSE), e.ps);
      if (e.m & 8) chk({e.nm, ".af"}, int'(almost_full), e.af);
      if (e.m & 16) chk({e.nm, ".ae"}, int'(almost_empty), e.ae);
    end
  end

  initial begin
    RESET = 1; init = 0;
    main_fifo_low = 1; main_fifo_high = 3; Vco_low = 3; Vco_high = 12; Vc1_low = 3; Vc1_high = 12;
    Do_low = 1; Do_high = 3; D1_low = 1; D1_high = 3;
    main_head_vc = 0; vc0_head_dest = 0; vc1_head_dest = 0;
    setc(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rchk("rst0");
    RESET = 0; init = 1;
    ex("init_enter", ALL, 1, 0, 0, 0, 1, 'h00, 'h1f);
    ex("init_hold", ALL, 1, 0, 0, 0, 1, 'h00, 'h1f);
    init = 0;
    ex("to_idle", ALL, 2, 0, 0, 0, 0, 'h00, 'h1f);
    setc(1, 0, 0, 0, 0);
    ex("to_active", ALL, 3, 1, 0, 0, 0, 'h00, 'h1f);
    setc(3, 0, 0, 0, 0);
    ex("main_af", ALL, 3, 1, 0, 0, 1, 'h01, 'h1e);
    setc(0, 2, 2, 0, 0);
    ex("arb0", ALL, 3, 0, 1, 0, 0, 'h00, 'h1f);
    ex("arb1", SP, 3, 0, 1 - RR, RR, 0);
    ex("arb2", SP, 3, 0, 1, 0, 0);
    vc1_head_dest = 1; setc(0, 0, 2, 0, 3);
    ex("d1_full", ALL, 3, 0, 0, 0, 0, 'h10, 'h0f);
    setc(0, 0, 2, 0, 2);
    ex("d1_free", ALL, 3, 0, 0, 1, 0, 'h00, 'h0f);
    vc1_head_dest = 0; setc(0, 0, 0, 0, 0);
    ex("back_idle", ALL, 2, 0, 0, 0, 0, 'h00, 'h1f);
    setc(1, 0, 0, 0, 0);
    ex("reactive", SP, 3, 1, 0, 0, 0);
    setc(17, 0, 0, 0, 0);
    ex("ovf", ALL, 4, 0, 0, 0, 1, 'h01, 'h1e);
    setc(0, 2, 0, 0, 0); init = 1;
    ex("err_sticky", SP, 4, 0, 0, 0, 1);
    RESET = 1;
    rchk("rst_err");
    RESET = 0; init = 1; Vco_low = 12; Vco_high = 3; setc(0, 0, 0, 0, 0);
    ex("bad_init", SP, 1, 0, 0, 0, 1);
    ex("bad_hold", SP, 1, 0, 0, 0, 1);
    init = 0;
    ex("bad_err", SP, 4, 0, 0, 0, 1);
    ex("bad_stay", SP, 4, 0, 0, 0, 1);
    RESET = 1;
    rchk("rst2");
    RESET = 0; init = 1; Vco_low = 3; Vco_high = 12;
    ex("init2", SP, 1, 0, 0, 0, 1);
    ex("init2b", SP, 1, 0, 0, 0, 1);
    init = 0;
    ex("idle2", SP, 2, 0, 0, 0, 0);
    setc(1, 0, 0, 0, 0);
    ex("act2", SP, 3, 1, 0, 0, 0);
    init = 1;
    #1 chk("init_supp.pop_main", int'(pop_main), 0);
    ex("act_to_init", SP, 1, 0, 0, 0, 1);
    init = 0;
    ex("init_idle", SP, 2, 0, 0, 0, 0);
    ex("idle_act", SP, 3, 1, 0, 0, 0);
    #2 RESET = 1;
    rchk("rst_mid");
    @(negedge clk);
    RESET = 0; init = 1;
    ex("init3", SP, 1, 0, 0, 0, 1);
    setc(17, 0, 0, 0, 0);
    ex("init_ovf", SP, 4, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
